mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//   Consumer side of the EX/MEM pipeline register: performs the MEM stage of the 64-bit RISC-V pipeline.
//   Issues loads/stores to a multi-cycle data memory over a req/ack handshake and stalls upstream while busy.
//   Resolves branches and drives the MEM/WB register outputs toward writeback.
// PARAMETERS
//   DATA_W    64  data/address width
//   REG_W     5   register index width
//   MAX_WAIT  16  BUSY cycles without ack before abort (>=1)
// PORTS
//   clk          in   1       clock, all state updates on posedge
//   reset        in   1       synchronous, active-high
//   MemRead      in   1       EX/MEM: load
//   MemWrite     in   1       EX/MEM: store
//   memToReg     in   1       EX/MEM: writeback selects memory data
//   regWrite     in   1       EX/MEM: register write enable
//   branch       in   1       EX/MEM: branch instruction
//   WriteData    in   DATA_W  EX/MEM: store data
//   add2         in   DATA_W  EX/MEM: branch target
//   rd           in   REG_W   EX/MEM: destination register
//   AluResult    in   DATA_W  EX/MEM: ALU result / memory address
//   zero         in   1       EX/MEM: ALU zero flag
//   dmem_req     out  1       memory request (registered)
//   dmem_we      out  1       1 = write, 0 = read
//   dmem_addr    out  DATA_W  memory address
//   dmem_wdata   out  DATA_W  store data
//   dmem_ack     in   1       memory completion, 1 cycle
//   dmem_rdata   in   DATA_W  load data, valid with dmem_ack
//   stall        out  1       hold PC, IF/ID, ID/EX, EX/MEM (combinational)
//   PCSrc        out  1       take branch (combinational)
//   branchTarget out  DATA_W  = add2
//   mem_err      out  1       1-cycle pulse on timeout abort
//   regWriteOut  out  1       MEM/WB register write enable
//   memToRegOut  out  1       MEM/WB writeback select
//   ReadDataOut  out  DATA_W  MEM/WB load data
//   AluResultOut out  DATA_W  MEM/WB ALU result
//   rdOut        out  REG_W   MEM/WB destination
// BEHAVIOUR
//   - Reset: every registered output 0, state IDLE, wait counter 0; the next posedge applies reset even mid-transaction.
//     An ack arriving after reset is ignored.
//   - memop = MemRead | MemWrite; both set -> treat as write.
//   - FSM IDLE/BUSY. stall = (IDLE & memop) | (BUSY & ~dmem_ack & ~timeout).
//   - IDLE, ~memop: MEM/WB registers load {regWrite, memToReg, AluResult, rd}, ReadDataOut <= 0; latency 1 cycle.
//   - IDLE, memop: stall=1. Posedge -> BUSY, dmem_req<=1, dmem_we<=MemWrite, addr<=AluResult, wdata<=WriteData.
//     Latches regWrite/memToReg/rd/AluResult. MEM/WB gets bubble (regWriteOut<=0).
//   - BUSY: req/we/addr/wdata held stable; counter increments each cycle; MEM/WB bubble each stalled cycle.
//   - BUSY & dmem_ack: stall=0 that cycle. Posedge: dmem_req<=0, IDLE, counter<=0.
//     MEM/WB loads latched controls; ReadDataOut<=dmem_rdata for reads, 0 for writes.
//   - timeout = BUSY & ~dmem_ack & counter==MAX_WAIT-1. stall=0 that cycle. Posedge: dmem_req<=0, IDLE, mem_err<=1 for 1 cycle, bubble.
//   - ack and timeout in the same cycle: ack wins, no mem_err.
//   - dmem_ack while IDLE: ignored.
//   - Counter width: clog2(MAX_WAIT)+1; never wraps.
//   - PCSrc = branch & zero & ~stall; branchTarget = add2 (combinational pass-through).
// TESTING
//   1. ALU op regWrite=1 rd=5 AluResult=0x1234 -> next edge regWriteOut=1 rdOut=5 AluResultOut=0x1234; stall never 1.
//   2. Load MemRead=1 memToReg=1 addr=0x100; ack 3 cycles after req with rdata=0xDEADBEEF -> stall=1 for 4 cycles,
//      dmem_addr=0x100; after ack edge ReadDataOut=0xDEADBEEF memToRegOut=1; regWriteOut=0 meanwhile.
//   3. Store MemWrite=1 addr=0x200 WriteData=0xAA, ack after 1 -> dmem_we=1 dmem_wdata=0xAA; after ack regWriteOut=0, ReadDataOut=0.
//   4. branch=1 zero=1 add2=0x40 -> PCSrc=1 branchTarget=0x40; zero=0 -> PCSrc=0.
//   5. Load, no ack, MAX_WAIT=16 -> 16 BUSY cycles, then mem_err pulses once, stall=0, dmem_req=0, regWriteOut=0.
//   6. reset=1 during BUSY, ack 1 cycle later -> all outputs 0, state IDLE, ack ignored, no MEM/WB write.

Source files
------------

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Brief    : MEM stage of the 64-bit RISC-V pipeline. Issues loads/stores to
//            a multi-cycle data memory over req/ack, stalls upstream while
//            busy, resolves branches and drives the MEM/WB register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
   parameter int DATA_W   = 64,
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              memToReg,
   input  logic              regWrite,
   input  logic              branch,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [DATA_W-1:0] add2,
   input  logic [REG_W-1:0]  rd,
   input  logic [DATA_W-1:0] AluResult,
   input  logic              zero,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              stall,
   output logic              PCSrc,
   output logic [DATA_W-1:0] branchTarget,
   output logic              mem_err,
   output logic              regWriteOut,
   output logic              memToRegOut,
   output logic [DATA_W-1:0] ReadDataOut,
   output logic [DATA_W-1:0] AluResultOut,
   output logic [REG_W-1:0]  rdOut
);

   localparam int              CNT_W       = $clog2(MAX_WAIT) + 1;
   localparam logic [CNT_W-1:0] c_LAST_WAIT = CNT_W'(MAX_WAIT - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_waitCnt;

   logic              r_req;
   logic              r_we;
   logic [DATA_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_memErr;

   // Controls of the in-flight memory instruction, retired on ack
   logic              r_regWriteL;
   logic              r_memToRegL;
   logic [REG_W-1:0]  r_rdL;
   logic [DATA_W-1:0] r_aluL;

   logic              r_regWriteOut;
   logic              r_memToRegOut;
   logic [DATA_W-1:0] r_readDataOut;
   logic [DATA_W-1:0] r_aluResultOut;
   logic [REG_W-1:0]  r_rdOut;

   logic              w_memop;
   logic              w_done;
   logic              w_timeout;
   logic              w_stall;

   always_comb begin
      w_memop     = MemRead | MemWrite;
      w_done      = (r_state == ST_BUSY) & dmem_ack;
      w_timeout   = (r_state == ST_BUSY) & ~dmem_ack & (r_waitCnt == c_LAST_WAIT);
      w_stall     = ((r_state == ST_IDLE) & w_memop) |
                    ((r_state == ST_BUSY) & ~dmem_ack & ~w_timeout);
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_memop) w_nextState = ST_BUSY;
         ST_BUSY: if (w_done | w_timeout) w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_waitCnt      <= '0;
         r_req          <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_memErr       <= 1'b0;
         r_regWriteL    <= 1'b0;
         r_memToRegL    <= 1'b0;
         r_rdL          <= '0;
         r_aluL         <= '0;
         r_regWriteOut  <= 1'b0;
         r_memToRegOut  <= 1'b0;
         r_readDataOut  <= '0;
         r_aluResultOut <= '0;
         r_rdOut        <= '0;
      end else begin
         r_memErr <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (w_memop) begin
               r_req          <= 1'b1;
               r_we           <= MemWrite;
               r_addr         <= AluResult;
               r_wdata        <= WriteData;
               r_waitCnt      <= '0;
               r_regWriteL    <= regWrite;
               r_memToRegL    <= memToReg;
               r_rdL          <= rd;
               r_aluL         <= AluResult;
               r_regWriteOut  <= 1'b0;
               r_memToRegOut  <= 1'b0;
               r_readDataOut  <= '0;
               r_aluResultOut <= '0;
               r_rdOut        <= '0;
            end else begin
               r_regWriteOut  <= regWrite;
               r_memToRegOut  <= memToReg;
               r_readDataOut  <= '0;
               r_aluResultOut <= AluResult;
               r_rdOut        <= rd;
            end
         end else if (w_done) begin
            r_req          <= 1'b0;
            r_waitCnt      <= '0;
            r_regWriteOut  <= r_regWriteL;
            r_memToRegOut  <= r_memToRegL;
            r_readDataOut  <= r_we ? '0 : dmem_rdata;
            r_aluResultOut <= r_aluL;
            r_rdOut        <= r_rdL;
         end else begin
            // Stalled or aborted: MEM/WB sees a bubble
            r_regWriteOut  <= 1'b0;
            r_memToRegOut  <= 1'b0;
            r_readDataOut  <= '0;
            r_aluResultOut <= '0;
            r_rdOut        <= '0;
            if (w_timeout) begin
               r_req     <= 1'b0;
               r_waitCnt <= '0;
               r_memErr  <= 1'b1;
            end else if (r_waitCnt != c_LAST_WAIT) begin
               r_waitCnt <= r_waitCnt + CNT_W'(1);
            end
         end
      end
   end

   assign dmem_req     = r_req;
   assign dmem_we      = r_we;
   assign dmem_addr    = r_addr;
   assign dmem_wdata   = r_wdata;
   assign mem_err      = r_memErr;
   assign stall        = w_stall;
   assign PCSrc        = branch & zero & ~w_stall;
   assign branchTarget = add2;
   assign regWriteOut  = r_regWriteOut;
   assign memToRegOut  = r_memToRegOut;
   assign ReadDataOut  = r_readDataOut;
   assign AluResultOut = r_aluResultOut;
   assign rdOut        = r_rdOut;

endmodule
`default_nettype wire
